// File: rtl/dcm_seq_pkg.sv
// Shared definitions for the DCM reset sequencer: state encoding, STATUS bit
// positions and default timing parameters.
package dcm_seq_pkg;

   typedef enum logic [2:0] {
      RESET_DCM = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_e;

   localparam int unsigned STATUS_CLKIN_STOPPED = 1;
   localparam int unsigned STATUS_CLKFX_STOPPED = 2;

   localparam int unsigned DEF_RST_CYCLES    = 8;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 65535;
   localparam int unsigned DEF_STABLE_CYCLES = 16;
   localparam int unsigned DEF_MAX_RETRIES   = 7;

   localparam int unsigned RETRY_W = 4;

endpackage : dcm_seq_pkg

// File: rtl/dcm_sync.sv
// Two-flop synchronizer for asynchronous level signals coming from the DCM.
module dcm_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : dcm_sync

// File: rtl/dcm_reset_sequencer.sv
// Drives DCM_SP RST through reset / lock / stabilisation attempts and holds the
// system in reset until the DCM has been cleanly locked for a while.
module dcm_reset_sequencer
   import dcm_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               dcm_locked_i,
   input  logic [2:0]         dcm_status_i,
   input  logic               restart_i,
   output logic               dcm_rst_o,
   output logic               sys_rst_o,
   output logic               ready_o,
   output logic               fail_o,
   output logic [RETRY_W-1:0] retry_cnt_o
);

   localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

   state_e             state_q, state_d;
   logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               dcm_rst_q, dcm_rst_d;
   logic               sys_rst_q, sys_rst_d;
   logic               ready_q, ready_d;
   logic               fail_q, fail_d;
   logic               attempt_fail;

   logic               locked;
   logic [1:0]         status_sync;
   logic               fault;
   logic               unused_status;

   dcm_sync #(.WIDTH(1)) u_sync_locked (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (dcm_locked_i),
      .q_o    (locked)
   );

   dcm_sync #(.WIDTH(2)) u_sync_status (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({dcm_status_i[STATUS_CLKFX_STOPPED], dcm_status_i[STATUS_CLKIN_STOPPED]}),
      .q_o    (status_sync)
   );

   assign fault         = |status_sync;
   assign unused_status = dcm_status_i[0];

   // Counters default to zero and only carry while staying in their state,
   // so every state entry starts from a cleared count.
   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = '0;
      to_cnt_d     = '0;
      stb_cnt_d    = '0;
      retry_d      = retry_q;
      attempt_fail = 1'b0;

      case (state_q)
         RESET_DCM: begin
            if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            else                                     rst_cnt_d = rst_cnt_q + RST_W'(1);
         end
         WAIT_LOCK: begin
            if (locked && !fault)                            state_d = STABLE;
            else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1))    attempt_fail = 1'b1;
            else                                             to_cnt_d = to_cnt_q + TO_W'(1);
         end
         STABLE: begin
            if (!locked || fault) begin
               attempt_fail = 1'b1;
            end else if (stb_cnt_q == STB_W'(STABLE_CYCLES - 1)) begin
               state_d = RUN;
               retry_d = '0;
            end else begin
               stb_cnt_d = stb_cnt_q + STB_W'(1);
            end
         end
         RUN: begin
            if (!locked || fault) state_d = RESET_DCM;
         end
         FAIL:    state_d = FAIL;
         default: state_d = RESET_DCM;
      endcase

      if (attempt_fail) begin
         if (retry_q != {RETRY_W{1'b1}}) retry_d = retry_q + RETRY_W'(1);
         state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? FAIL : RESET_DCM;
      end

      if (restart_i) begin
         state_d   = RESET_DCM;
         rst_cnt_d = '0;
         to_cnt_d  = '0;
         stb_cnt_d = '0;
         retry_d   = '0;
      end

      // Outputs are decoded from the next state so they register with it.
      dcm_rst_d = (state_d == RESET_DCM) || (state_d == FAIL);
      sys_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
      fail_d    = (state_d == FAIL);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RESET_DCM;
         rst_cnt_q <= '0;
         to_cnt_q  <= '0;
         stb_cnt_q <= '0;
         retry_q   <= '0;
         dcm_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         to_cnt_q  <= to_cnt_d;
         stb_cnt_q <= stb_cnt_d;
         retry_q   <= retry_d;
         dcm_rst_q <= dcm_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   assign dcm_rst_o   = dcm_rst_q;
   assign sys_rst_o   = sys_rst_q;
   assign ready_o     = ready_q;
   assign fail_o      = fail_q;
   assign retry_cnt_o = retry_q;

endmodule : dcm_reset_sequencer

// File: tb/tb_dcm_reset_sequencer.sv
// Directed bench for dcm_reset_sequencer with short timing parameters; all
// expected values are hand-derived edge counts.
module tb_dcm_reset_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       dcm_locked_i;
   logic [2:0] dcm_status_i;
   logic       restart_i;
   logic       dcm_rst_o;
   logic       sys_rst_o;
   logic       ready_o;
   logic       fail_o;
   logic [3:0] retry_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   dcm_reset_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (5),
      .MAX_RETRIES   (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .dcm_locked_i (dcm_locked_i),
      .dcm_status_i (dcm_status_i),
      .restart_i    (restart_i),
      .dcm_rst_o    (dcm_rst_o),
      .sys_rst_o    (sys_rst_o),
      .ready_o      (ready_o),
      .fail_o       (fail_o),
      .retry_cnt_o  (retry_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_dcm_rst"}, 32'(dcm_rst_o),   32'd1);
      check({tag, "_sys_rst"}, 32'(sys_rst_o),   32'd1);
      check({tag, "_ready"},   32'(ready_o),     32'd0);
      check({tag, "_fail"},    32'(fail_o),      32'd0);
      check({tag, "_retry"},   32'(retry_cnt_o), 32'd0);
   endtask

   initial begin
      rst_ni       = 1'b0;
      dcm_locked_i = 1'b0;
      dcm_status_i = 3'b000;
      restart_i    = 1'b0;
      step(3);
      check_reset_values("por");

      // Nominal bring-up: release just after an edge; e1 is the next edge.
      rst_ni = 1'b1;
      step(3);
      check("nom_rst_hi_e3", 32'(dcm_rst_o), 32'd1);
      step(1);
      check("nom_rst_lo_e4", 32'(dcm_rst_o), 32'd0);
      step(3);
      dcm_locked_i = 1'b1;
      step(7);
      check("nom_sysrst_hi_7", 32'(sys_rst_o), 32'd1);
      step(1);
      check("nom_sysrst_lo_8", 32'(sys_rst_o), 32'd0);
      check("nom_ready",       32'(ready_o),   32'd1);
      check("nom_dcm_rst",     32'(dcm_rst_o), 32'd0);
      check("nom_retry",       32'(retry_cnt_o), 32'd0);

      // Loss in RUN via CLKIN-stopped status.
      dcm_status_i = 3'b010;
      step(2);
      check("loss_ready_2", 32'(ready_o), 32'd1);
      step(1);
      check("loss_sysrst_3", 32'(sys_rst_o),   32'd1);
      check("loss_dcmrst_3", 32'(dcm_rst_o),   32'd1);
      check("loss_ready_3",  32'(ready_o),     32'd0);
      check("loss_retry",    32'(retry_cnt_o), 32'd0);
      dcm_status_i = 3'b000;

      // Glitch in STABLE: one-cycle lock drop seen when the stable count is 3.
      step(6);
      dcm_locked_i = 1'b0;
      step(1);
      dcm_locked_i = 1'b1;
      step(1);
      check("glitch_sysrst_pre", 32'(sys_rst_o), 32'd1);
      step(1);
      check("glitch_retry",  32'(retry_cnt_o), 32'd1);
      check("glitch_dcmrst", 32'(dcm_rst_o),   32'd1);
      check("glitch_sysrst", 32'(sys_rst_o),   32'd1);

      // Recovery to RUN clears retry count.
      step(9);
      check("recover_ready_pre", 32'(ready_o), 32'd0);
      step(1);
      check("recover_ready", 32'(ready_o),     32'd1);
      check("recover_retry", 32'(retry_cnt_o), 32'd0);

      // Asynchronous reset between edges.
      #3;
      rst_ni = 1'b0;
      #1;
      check_reset_values("async");
      dcm_locked_i = 1'b0;
      step(2);

      // Timeout path: lock never arrives.
      rst_ni = 1'b1;
      step(4);
      check("to_wait_e4",   32'(dcm_rst_o),   32'd0);
      step(19);
      check("to_wait_e23",  32'(dcm_rst_o),   32'd0);
      check("to_retry_e23", 32'(retry_cnt_o), 32'd0);
      step(1);
      check("to_pulse2_start", 32'(dcm_rst_o),   32'd1);
      check("to_retry1",       32'(retry_cnt_o), 32'd1);
      step(3);
      check("to_pulse2_hi", 32'(dcm_rst_o), 32'd1);
      step(1);
      check("to_pulse2_lo", 32'(dcm_rst_o), 32'd0);
      step(19);
      check("to_fail_pre", 32'(fail_o), 32'd0);
      step(1);
      check("to_fail",        32'(fail_o),      32'd1);
      check("to_fail_retry",  32'(retry_cnt_o), 32'd2);
      check("to_fail_dcmrst", 32'(dcm_rst_o),   32'd1);
      check("to_fail_sysrst", 32'(sys_rst_o),   32'd1);
      check("to_fail_ready",  32'(ready_o),     32'd0);
      step(5);
      check("to_fail_hold", 32'(fail_o), 32'd1);

      // Restart out of FAIL.
      restart_i = 1'b1;
      step(1);
      restart_i = 1'b0;
      check("rs_fail",   32'(fail_o),      32'd0);
      check("rs_dcmrst", 32'(dcm_rst_o),   32'd1);
      check("rs_retry",  32'(retry_cnt_o), 32'd0);
      check("rs_sysrst", 32'(sys_rst_o),   32'd1);

      // Restart on the same edge as a lock timeout must win.
      step(23);
      check("rs_wait_lo",    32'(dcm_rst_o),   32'd0);
      check("rs_wait_retry", 32'(retry_cnt_o), 32'd0);
      restart_i = 1'b1;
      step(1);
      restart_i = 1'b0;
      check("rs_prio_retry",  32'(retry_cnt_o), 32'd0);
      check("rs_prio_dcmrst", 32'(dcm_rst_o),   32'd1);
      check("rs_prio_fail",   32'(fail_o),      32'd0);
      step(3);
      check("rs_pulse_hi", 32'(dcm_rst_o), 32'd1);
      step(1);
      check("rs_pulse_lo", 32'(dcm_rst_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dcm_reset_sequencer

// File: doc/dcm_reset_sequencer.md
DCM_RESET_SEQUENCER -- requirements
Module: dcm_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 8: number of clk_i cycles dcm_rst_o is held high per attempt (min 3).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: number of WAIT_LOCK cycles allowed before an attempt counts as failed.
REQ-003 SHALL have parameter STABLE_CYCLES, default 16: consecutive clean locked cycles required before reset release.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: number of failed attempts that sends the block to FAIL.
REQ-005 clk_i  in  1  single clock, board input clock (pre-DCM).
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 dcm_locked_i  in  1  DCM_SP LOCKED, asynchronous.
REQ-008 dcm_status_i  in  3  DCM_SP STATUS[2:0]: bit1 CLKIN stopped, bit2 CLKFX stopped, bit0 ignored; asynchronous.
REQ-009 restart_i  in  1  synchronous pulse; forces a fresh sequence.
REQ-010 dcm_rst_o  out  1  DCM_SP RST, active high.
REQ-011 sys_rst_o  out  1  core/bus reset, active high.
REQ-012 ready_o  out  1  high only in RUN.
REQ-013 fail_o  out  1  high only in FAIL.
REQ-014 retry_cnt_o  out  4  failed attempts since the last RUN or restart; saturates at 15.

Function
REQ-015 dcm_locked_i and dcm_status_i[2:1] SHALL pass through 2-FF synchronizers; "locked" and "fault" below mean synchronized values, with fault = status[1] | status[2].
REQ-016 FSM states: RESET_DCM, WAIT_LOCK, STABLE, RUN, FAIL; every output SHALL be registered.
REQ-017 RESET_DCM: dcm_rst_o = 1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-018 WAIT_LOCK: dcm_rst_o = 0.
- locked & !fault -> STABLE.
- Timeout counter reaches LOCK_TIMEOUT -> failed attempt.
REQ-019 STABLE: a counter increments while locked & !fault.
- Counter reaches STABLE_CYCLES -> RUN.
- Any cycle with !locked or fault -> failed attempt.
REQ-020 Failed attempt: retry_cnt increments.
- New count == MAX_RETRIES -> FAIL.
- Otherwise -> RESET_DCM.
REQ-021 RUN:
- sys_rst_o = 0 and ready_o = 1 from the first RUN cycle.
- retry_cnt clears on entry.
REQ-022 RUN with !locked or fault -> RESET_DCM; sys_rst_o = 1 and ready_o = 0 in the next cycle; not counted as a failed attempt.
REQ-023 FAIL: terminal; fail_o = 1, sys_rst_o = 1, dcm_rst_o = 1; exits only on restart_i or rst_ni.
REQ-024 restart_i in any state: -> RESET_DCM next cycle, retry_cnt cleared, all counters cleared; restart_i has priority over every other transition.
REQ-025 sys_rst_o SHALL be 1 in every state except RUN.
REQ-026 Every counter SHALL clear on every state entry.
REQ-027 Counter widths SHALL be $clog2(param+1); no wrap-around.
REQ-028 Latency, dcm_locked_i rise (stable) in WAIT_LOCK to sys_rst_o fall: 2 sync cycles + 1 transition cycle + STABLE_CYCLES.

Reset
REQ-029 While rst_ni = 0 (asynchronous):
- state = RESET_DCM, dcm_rst_o = 1, sys_rst_o = 1.
- ready_o = 0, fail_o = 0, retry_cnt_o = 0.
- Synchronizers and counters cleared.
REQ-030 After rst_ni rises, the RESET_DCM count SHALL start on the first clk_i edge; reset asserted mid-sequence SHALL abort immediately to these values.

Structure
REQ-031 Package dcm_seq_pkg SHALL hold the state encoding, the STATUS bit indices and the parameter defaults.
REQ-032 Sub-module dcm_sync (parameterised-width 2-FF synchronizer, async active-low clear) SHALL be instantiated for locked and status; all other logic SHALL reside in dcm_reset_sequencer.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=5, MAX_RETRIES=2)
REQ-033 Nominal: release rst_ni; raise dcm_locked_i 3 cycles into WAIT_LOCK -> dcm_rst_o high exactly 4 cycles; sys_rst_o falls 8 cycles after dcm_locked_i rises; ready_o = 1.
REQ-034 Timeout: hold dcm_locked_i = 0 -> two 4-cycle dcm_rst_o pulses 20 cycles apart; after the second timeout fail_o = 1, retry_cnt_o = 2.
REQ-035 Glitch in STABLE: drop dcm_locked_i for 1 cycle at stable count 3 -> returns to RESET_DCM, retry_cnt_o = 1, sys_rst_o stays 1.
REQ-036 Loss in RUN: set dcm_status_i[1] = 1 -> sys_rst_o = 1 and dcm_rst_o = 1 three cycles later (2 sync + 1); retry_cnt_o stays 0.
REQ-037 Restart from FAIL: pulse restart_i -> next cycle fail_o = 0, dcm_rst_o = 1, retry_cnt_o = 0; same cycle as a timeout -> restart wins.
REQ-038 Async reset: assert rst_ni in RUN between clock edges -> all outputs at reset values before the next edge.
